// File: rtl/simple_read_streamer_if.sv
// Bus bundle for simple_read_streamer: the read-request/response channel toward memory
// (m_*) and the outgoing data stream (s_*).
//   master : the streamer side (issues requests, receives beats, drives the stream)
//   slave  : the environment side (memory responder plus stream consumer)
interface simple_read_streamer_if #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned LEN_W      = 8
);
  logic                  m_rvalid_o;
  logic [AXI_ADDR_W-1:0] m_raddr_o;
  logic [LEN_W-1:0]      m_rlen_o;
  logic                  m_rready_i;
  logic [AXI_DATA_W-1:0] m_rdata_i;
  logic                  m_rlast_i;
  logic                  s_valid_o;
  logic                  s_ready_i;
  logic [AXI_DATA_W-1:0] s_data_o;
  logic                  s_last_o;

  modport master (
    output m_rvalid_o, m_raddr_o, m_rlen_o,
    input  m_rready_i, m_rdata_i, m_rlast_i,
    output s_valid_o, s_data_o, s_last_o,
    input  s_ready_i
  );

  modport slave (
    input  m_rvalid_o, m_raddr_o, m_rlen_o,
    output m_rready_i, m_rdata_i, m_rlast_i,
    input  s_valid_o, s_data_o, s_last_o,
    output s_ready_i
  );
endinterface

// File: rtl/simple_read_streamer.sv
// Splits a byte-addressed read transfer into chunked requests, buffers the returned words
// in a first-word-fall-through FIFO and streams them out, flagging the final word.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i, addr_i, total_len_i : transfer command
//   busy_o, done_o, overflow_o   : status (done_o is a one-cycle pulse, overflow_o sticky)
//   bus (master)                 : request channel m_* and output stream s_*
module simple_read_streamer #(
  parameter int unsigned AXI_ADDR_W  = 32,
  parameter int unsigned AXI_DATA_W  = 32,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TOTAL_W     = 20,
  parameter int unsigned CHUNK_BYTES = 64,
  parameter int unsigned FIFO_LOG2   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [TOTAL_W-1:0]    total_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  simple_read_streamer_if.master bus
);

  localparam int unsigned BYTES      = AXI_DATA_W / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(BYTES);
  localparam int unsigned DEPTH      = 2 ** FIFO_LOG2;
  localparam int unsigned CNT_W      = FIFO_LOG2 + 1;

  typedef enum logic [2:0] {StIdle, StWaitSpace, StReq, StRecv, StDrain} state_e;

  state_e                state_q;
  logic [AXI_ADDR_W-1:0] cur_addr_q;
  logic [TOTAL_W-1:0]    remaining_q;
  logic [TOTAL_W-1:0]    last_idx_q;
  logic [TOTAL_W-1:0]    word_out_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rvalid_q;
  logic [AXI_ADDR_W-1:0] raddr_q;
  logic [LEN_W-1:0]      rlen_q;

  logic [AXI_DATA_W-1:0] mem_q [DEPTH];
  logic [FIFO_LOG2-1:0]  wr_ptr_q;
  logic [FIFO_LOG2-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  overflow_q;

  logic [TOTAL_W-1:0]    chunk;
  logic [TOTAL_W:0]      chunk_words;
  logic [TOTAL_W:0]      total_words;
  logic [CNT_W-1:0]      free_entries;
  logic                  space_ok;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  last_word;

  always_comb begin
    chunk        = (remaining_q < TOTAL_W'(CHUNK_BYTES)) ? remaining_q : TOTAL_W'(CHUNK_BYTES);
    chunk_words  = ({1'b0, chunk} + (TOTAL_W + 1)'(BYTES - 1)) >> BYTE_SHIFT;
    total_words  = ({1'b0, total_len_i} + (TOTAL_W + 1)'(BYTES - 1)) >> BYTE_SHIFT;
    free_entries = CNT_W'(DEPTH) - cnt_q;
    space_ok     = 32'(chunk_words) <= 32'(free_entries);
    fifo_empty   = (cnt_q == '0);
    fifo_full    = (cnt_q == CNT_W'(DEPTH));
    // Beats are only meaningful while a request is outstanding; elsewhere they are dropped.
    push_req     = bus.m_rready_i && ((state_q == StReq) || (state_q == StRecv));
    push         = push_req && !fifo_full;
    pop          = !fifo_empty && bus.s_ready_i;
    last_word    = !fifo_empty && (word_out_q == last_idx_q);
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overflow_o     = overflow_q;
  assign bus.m_rvalid_o = rvalid_q;
  assign bus.m_raddr_o  = raddr_q;
  assign bus.m_rlen_o   = rlen_q;
  assign bus.s_valid_o  = !fifo_empty;
  assign bus.s_data_o   = mem_q[rd_ptr_q];
  assign bus.s_last_o   = last_word;

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      last_idx_q  <= '0;
      word_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      raddr_q     <= '0;
      rlen_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        word_out_q <= word_out_q + TOTAL_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (total_len_i != '0) begin
              cur_addr_q  <= addr_i;
              remaining_q <= total_len_i;
              last_idx_q  <= TOTAL_W'(total_words - (TOTAL_W + 1)'(1));
              word_out_q  <= '0;
              busy_q      <= 1'b1;
              state_q     <= StWaitSpace;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StWaitSpace: begin
          // Only request what the FIFO is guaranteed to absorb, since beats cannot stall.
          if (space_ok) begin
            rvalid_q <= 1'b1;
            raddr_q  <= cur_addr_q;
            rlen_q   <= LEN_W'(chunk);
            state_q  <= StReq;
          end
        end
        StReq, StRecv: begin
          if (bus.m_rready_i) begin
            rvalid_q <= 1'b0;
            if (bus.m_rlast_i) begin
              // remaining_q is untouched while a request is outstanding, so chunk still
              // equals the length that was issued.
              cur_addr_q  <= cur_addr_q + AXI_ADDR_W'(chunk);
              remaining_q <= remaining_q - chunk;
              state_q     <= (remaining_q == chunk) ? StDrain : StWaitSpace;
            end else begin
              state_q <= StRecv;
            end
          end
        end
        StDrain: begin
          if (pop && last_word) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.m_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_LOG2'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (push_req && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_simple_read_streamer.sv
module tb_simple_read_streamer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned TW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr;
  logic [TW-1:0] total_len;
  logic          busy;
  logic          done;
  logic          overflow;

  simple_read_streamer_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) bus ();

  simple_read_streamer #(
    .AXI_ADDR_W (AW),
    .AXI_DATA_W (DW),
    .LEN_W      (LW),
    .TOTAL_W    (TW),
    .CHUNK_BYTES(64),
    .FIFO_LOG2  (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .addr_i     (addr),
    .total_len_i(total_len),
    .busy_o     (busy),
    .done_o     (done),
    .overflow_o (overflow),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents seen by the responder and by the model.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Behavioural model: expected request list and expected stream contents.
  logic [31:0] exp_data[$];
  logic [31:0] exp_raddr[$];
  int          exp_rlen[$];
  int          exp_words;
  int          popped;
  bit          done_seen;
  bit          in_xfer;
  logic [31:0] log_raddr[$];
  int          log_rlen[$];
  bit          have_prev;
  bit          chk_gap;
  int          resp_delay;

  task automatic model_start(input logic [31:0] a, input int len);
    int rem;
    int c;
    logic [31:0] ca;
    exp_data.delete();
    exp_raddr.delete();
    exp_rlen.delete();
    log_raddr.delete();
    log_rlen.delete();
    rem = len;
    ca  = a;
    while (rem > 0) begin
      c = (rem < 64) ? rem : 64;
      exp_raddr.push_back(ca);
      exp_rlen.push_back(c);
      ca  = ca + c;
      rem = rem - c;
    end
    exp_words = (len + 3) / 4;
    for (int i = 0; i < exp_words; i++) exp_data.push_back(memf(a + 32'(4 * i)));
    popped    = 0;
    done_seen = 1'b0;
    have_prev = 1'b0;
    in_xfer   = 1'b1;
  endtask

  task automatic start_xfer(input logic [31:0] a, input int len);
    model_start(a, len);
    @(posedge clk); #1;
    addr      = a;
    total_len = len[TW-1:0];
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) @(posedge clk);
    #1;
    check("done_within_budget", done_seen, 1);
    check("busy_after_done", busy, 0);
  endtask

  // Memory responder: answers each request with ceil(len/4) back-to-back beats.
  int          beats_left = 0;
  int          delay_cnt  = 0;
  int          cyc        = 0;
  int          last_beat_cyc = 0;
  logic [31:0] beat_addr;
  bit          beat_driven = 1'b0;

  initial begin
    bus.m_rready_i = 1'b0;
    bus.m_rdata_i  = '0;
    bus.m_rlast_i  = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        beats_left     = 0;
        beat_driven    = 1'b0;
        bus.m_rready_i = 1'b0;
        bus.m_rlast_i  = 1'b0;
      end else begin
        if (beat_driven) check("rvalid_low_after_beat", bus.m_rvalid_o, 0);
        beat_driven    = 1'b0;
        bus.m_rready_i = 1'b0;
        bus.m_rlast_i  = 1'b0;
        if (beats_left == 0 && bus.m_rvalid_o) begin
          if (exp_raddr.size() == 0) begin
            check("unexpected_request", bus.m_rvalid_o, 0);
          end else begin
            check("req_addr", bus.m_raddr_o, exp_raddr.pop_front());
            check("req_len", bus.m_rlen_o, exp_rlen.pop_front());
          end
          if (chk_gap && have_prev) check("req_gap_le2", (cyc - last_beat_cyc) <= 3, 1);
          have_prev = 1'b1;
          log_raddr.push_back(bus.m_raddr_o);
          log_rlen.push_back(int'(bus.m_rlen_o));
          beats_left = (int'(bus.m_rlen_o) + 3) / 4;
          if (beats_left == 0) beats_left = 1;
          beat_addr = bus.m_raddr_o;
          delay_cnt = resp_delay;
        end
        if (beats_left > 0) begin
          if (delay_cnt > 0) begin
            check("rvalid_held", bus.m_rvalid_o, 1);
            check("raddr_stable", bus.m_raddr_o, beat_addr);
            delay_cnt--;
          end else begin
            bus.m_rready_i = 1'b1;
            bus.m_rdata_i  = memf(beat_addr);
            bus.m_rlast_i  = (beats_left == 1);
            beat_addr      = beat_addr + 32'd4;
            beats_left--;
            last_beat_cyc  = cyc;
            beat_driven    = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: every popped word and every done pulse against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.s_valid_o && bus.s_ready_i) begin
          if (exp_data.size() == 0) begin
            check("unexpected_word", bus.s_valid_o, 0);
          end else begin
            check("s_data", bus.s_data_o, exp_data.pop_front());
            check("s_last", bus.s_last_o, popped == exp_words - 1);
          end
          popped++;
        end
        if (done) begin
          check("done_expected", in_xfer && (popped == exp_words), 1);
          done_seen = 1'b1;
          in_xfer   = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rvalid", bus.m_rvalid_o, 0);
    check("rst_svalid", bus.s_valid_o, 0);
    check("rst_slast", bus.s_last_o, 0);
    check("rst_raddr", bus.m_raddr_o, 0);
    check("rst_rlen", bus.m_rlen_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    addr          = '0;
    total_len     = '0;
    bus.s_ready_i = 1'b1;
    chk_gap       = 1'b0;
    resp_delay    = 0;
    in_xfer       = 1'b0;
    exp_words     = 0;
    popped        = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_request", bus.m_rvalid_o, 0);

    // Short transfer: one request, four words.
    start_xfer(32'h1000, 16);
    check("busy_after_start", busy, 1);
    wait_done(100);
    check("t1_nreq", log_raddr.size(), 1);
    check("t1_addr", log_raddr[0], 32'h1000);
    check("t1_len", log_rlen[0], 16);
    check("t1_words", popped, 4);

    // Multi-chunk transfer, with a start pulse while busy that must be ignored.
    chk_gap = 1'b1;
    start_xfer(32'h2000, 200);
    @(posedge clk); #1;
    addr      = 32'h9000;
    total_len = 20'd8;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    chk_gap = 1'b0;
    check("t2_nreq", log_raddr.size(), 4);
    check("t2_addr1", log_raddr[1], 32'h2040);
    check("t2_addr3", log_raddr[3], 32'h20C0);
    check("t2_len3", log_rlen[3], 8);
    check("t2_words", popped, 50);

    // Stream stalled: FIFO fills with 16 words and no second request goes out.
    bus.s_ready_i = 1'b0;
    start_xfer(32'h4000, 100);
    repeat (40) @(posedge clk);
    #1;
    check("t3_nreq_stalled", log_raddr.size(), 1);
    check("t3_rvalid_stalled", bus.m_rvalid_o, 0);
    check("t3_svalid_stalled", bus.s_valid_o, 1);
    check("t3_popped_stalled", popped, 0);
    bus.s_ready_i = 1'b1;
    wait_done(300);
    check("t3_nreq", log_raddr.size(), 2);
    check("t3_addr1", log_raddr[1], 32'h4040);
    check("t3_len1", log_rlen[1], 36);
    check("t3_words", popped, 25);

    // Single-beat chunk.
    start_xfer(32'h5000, 4);
    wait_done(100);
    check("t4_len", log_rlen[0], 4);
    check("t4_words", popped, 1);

    // Slow responder: request must hold until the first beat.
    resp_delay = 3;
    start_xfer(32'h7000, 12);
    wait_done(100);
    resp_delay = 0;
    check("t5_words", popped, 3);

    // Zero-length transfer.
    start_xfer(32'h6000, 0);
    check("t6_done_pulse", done, 1);
    check("t6_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t6_done_cleared", done, 0);
    check("t6_nreq", log_raddr.size(), 0);

    // Reset in the middle of receiving, then a fresh transfer.
    bus.s_ready_i = 1'b0;
    start_xfer(32'h3000, 64);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    in_xfer = 1'b0;
    exp_data.delete();
    exp_raddr.delete();
    exp_rlen.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t7_no_req_after_rst", bus.m_rvalid_o, 0);
    bus.s_ready_i = 1'b1;
    start_xfer(32'h3100, 24);
    wait_done(100);
    check("t7_nreq", log_raddr.size(), 1);
    check("t7_words", popped, 6);
    check("final_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
